chess_turn_scheduler: RTL
=========================

CHESS_TURN_SCHEDULER -- requirements
Module: chess_turn_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, meaning clock cycles per one-second tick (legal range 2..2^26).
REQ-002 The block SHALL have parameter PLY_WIDTH, default 10, meaning the width of the ply counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-004 Ports (name  direction  width  meaning):
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- startStop  in  1  level; 1 = play, 0 = pause request
- newGame  in  1  one-cycle pulse; abandon game, return to IDLE
- moveCommit  in  1  one-cycle pulse; side to move has locked a legal move
- checkmate  in  2  [0] mate detected; [1] mating side (0 white, 1 black)
- whiteTimeout  in  1  level; white clock reached 0:00
- blackTimeout  in  1  level; black clock reached 0:00
- whiteRun  out  1  enable for white countdown timer
- blackRun  out  1  enable for black countdown timer
- secTick  out  1  one-cycle one-second strobe for the running timer
- player  out  1  side to move (0 white, 1 black)
- gameState  out  3  0 IDLE, 1 WHITE, 2 BLACK, 3 PAUSE, 4 OVER
- winner  out  2  00 none, 01 white, 10 black; 11 never driven
- plyCount  out  PLY_WIDTH  half-moves committed this game

Function
REQ-005 All outputs SHALL be registered; every transition takes effect on the clock edge after the causing input is sampled.
REQ-006 IDLE: whiteRun = blackRun = 0; prescaler held at 0; startStop = 1 -> WHITE, with plyCount <= 0, winner <= 00, player <= 0.
REQ-007 WHITE / BLACK: exactly the run output of the side to move SHALL be 1; the other run output SHALL be 0.
REQ-008 moveCommit in WHITE -> BLACK, and in BLACK -> WHITE; plyCount increments by 1 and saturates at 2^PLY_WIDTH-1.
REQ-009 moveCommit in IDLE, PAUSE or OVER SHALL be ignored; plyCount is unchanged.
REQ-010 startStop = 0 in WHITE / BLACK -> PAUSE; the side to move is saved in player; both run outputs are 0; the prescaler freezes at its current value.
REQ-011 PAUSE with startStop = 1 -> the saved side's state (WHITE or BLACK); the prescaler resumes from its frozen value.
REQ-012 The prescaler SHALL count only in WHITE / BLACK; at count TICK_DIV-1 it wraps to 0 and secTick = 1 for exactly that one cycle; secTick is never 1 in any other state.
REQ-013 End of game, evaluated in WHITE, BLACK and PAUSE:
- checkmate[0] = 1 -> OVER, winner = 01 if checkmate[1] = 0, else 10.
- whiteTimeout alone -> OVER, winner = 10.
- blackTimeout alone -> OVER, winner = 01.
- Both timeouts together -> the side to move loses.
REQ-014 OVER: run outputs 0; secTick 0; winner, player and plyCount held; exit only via newGame or reset.
REQ-015 newGame in any state -> IDLE; winner <= 00; plyCount <= 0; player <= 0; prescaler <= 0.
REQ-016 Same-cycle priority SHALL be: reset > newGame > checkmate / timeout > startStop = 0 > moveCommit.
- A moveCommit that loses priority SHALL NOT be counted.
- A timeout arriving with moveCommit ends the game with the pre-move side to move.
REQ-017 secTick coinciding with moveCommit SHALL be attributed to the side to move before the switch; the prescaler does not restart on a turn change.
REQ-018 gameState values 5-7 SHALL be unreachable; if entered, the next cycle -> IDLE with IDLE reset values.

Reset
REQ-019 reset = 1 at a clock edge SHALL force the following, overriding all other inputs including mid-game:
- gameState = IDLE (0), player = 0, winner = 00, plyCount = 0
- whiteRun = blackRun = secTick = 0, prescaler = 0

Verification (TICK_DIV = 4)
REQ-020 Reset, then startStop = 1 -> gameState = 1 next cycle, whiteRun = 1, secTick high every 4th cycle, plyCount = 0.
REQ-021 Three moveCommit pulses 10 cycles apart -> gameState 2, 1, 2, player toggles, plyCount = 3, run outputs never both 1.
REQ-022 startStop = 0 at prescaler = 2 for 20 cycles, then 1 -> PAUSE with no secTick; return to the same side; the first secTick arrives 2 cycles after resume.
REQ-023 In BLACK, moveCommit and blackTimeout asserted in the same cycle -> gameState = 4, winner = 01, plyCount unchanged.
REQ-024 checkmate = 2'b11 in WHITE -> OVER with winner = 10; later moveCommit and startStop toggles leave it unchanged; newGame -> IDLE, winner = 00.
REQ-025 Drive plyCount to saturation with PLY_WIDTH = 2 -> count holds at 3; reset mid-game -> all REQ-019 values on the next edge.

Source files
------------

// File: rtl/chess_turn_scheduler.sv
// Chess game turn scheduler: tracks side to move, pause/resume, end of game,
// ply count, and a one-second prescaler for the running side's clock.
module chess_turn_scheduler #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned PLY_WIDTH = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 startStop,
  input  logic                 newGame,
  input  logic                 moveCommit,
  input  logic [1:0]           checkmate,
  input  logic                 whiteTimeout,
  input  logic                 blackTimeout,
  output logic                 whiteRun,
  output logic                 blackRun,
  output logic                 secTick,
  output logic                 player,
  output logic [2:0]           gameState,
  output logic [1:0]           winner,
  output logic [PLY_WIDTH-1:0] plyCount
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_WHITE = 2'b01;
  localparam logic [1:0] WIN_BLACK = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WHITE = 3'd1,
    S_BLACK = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [1:0]              winner_d;
  logic                    player_d;
  logic                    ply_inc;
  logic                    clear;
  logic                    side;
  logic                    game_end;
  logic [1:0]              end_winner;
  logic                    run_q, run_d;

  assign gameState = 3'(state_q);

  // Side to move: the running state, or the side saved when paused.
  assign side     = (state_q == S_BLACK) || ((state_q == S_PAUSE) && player);
  assign game_end = checkmate[0] | whiteTimeout | blackTimeout;

  always_comb begin
    end_winner = WIN_NONE;
    if (checkmate[0])                      end_winner = checkmate[1] ? WIN_BLACK : WIN_WHITE;
    else if (whiteTimeout && blackTimeout) end_winner = side ? WIN_WHITE : WIN_BLACK;
    else if (whiteTimeout)                 end_winner = WIN_BLACK;
    else if (blackTimeout)                 end_winner = WIN_WHITE;
  end

  // Next-state decode in priority order: newGame, end of game, pause, move.
  always_comb begin
    state_d  = state_q;
    winner_d = winner;
    player_d = player;
    ply_inc  = 1'b0;
    clear    = 1'b0;
    if (newGame) begin
      state_d = S_IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (startStop) begin
            state_d = S_WHITE;
            clear   = 1'b1;
          end
        end
        S_WHITE, S_BLACK: begin
          if (game_end) begin
            state_d  = S_OVER;
            winner_d = end_winner;
          end else if (!startStop) begin
            state_d  = S_PAUSE;
            player_d = side;
          end else if (moveCommit) begin
            state_d  = side ? S_WHITE : S_BLACK;
            player_d = ~side;
            ply_inc  = 1'b1;
          end
        end
        S_PAUSE: begin
          if (game_end) begin
            state_d  = S_OVER;
            winner_d = end_winner;
          end else if (startStop) begin
            state_d = player ? S_BLACK : S_WHITE;
          end
        end
        S_OVER: state_d = S_OVER;
        default: begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      endcase
    end
  end

  assign run_q = (state_q == S_WHITE) || (state_q == S_BLACK);
  assign run_d = (state_d == S_WHITE) || (state_d == S_BLACK);

  // A tick already issued at PRE_MAX still wraps when play stops, so resuming
  // never repeats it; otherwise the count freezes outside play.
  always_comb begin
    pre_d = pre_q;
    if (clear || (state_d == S_IDLE)) begin
      pre_d = '0;
    end else if (run_q) begin
      if (pre_q == PRE_MAX) pre_d = '0;
      else if (run_d)       pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      winner   <= WIN_NONE;
      player   <= 1'b0;
      plyCount <= '0;
      whiteRun <= 1'b0;
      blackRun <= 1'b0;
      secTick  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      winner   <= clear ? WIN_NONE : winner_d;
      player   <= clear ? 1'b0 : player_d;
      if (clear)
        plyCount <= '0;
      else if (ply_inc && (plyCount != {PLY_WIDTH{1'b1}}))
        plyCount <= plyCount + PLY_WIDTH'(1);
      whiteRun <= (state_d == S_WHITE);
      blackRun <= (state_d == S_BLACK);
      secTick  <= run_d && (pre_d == PRE_MAX);
    end
  end

endmodule
